// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size/FSM types and lane geometry for the LSU memory stage
package mem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;
  localparam int XLEN_DEF = 64;
  localparam int STRB_W = XLEN_DEF / 8;
  localparam int OFF_W = $clog2(STRB_W);
  function automatic logic misaligned(input logic [OFF_W-1:0] lo, input mem_size_e s);
    return (lo & {s == SZ_D, s >= SZ_W, s >= SZ_H}) != '0;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane store strobe/data placement and load extract with sign/zero extension
module lsu_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  mem_size_e                 size,
  input  logic                      is_unsigned,
  input  logic [XLEN-1:0]           store_data,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN/8-1:0]         wstrb,
  output logic [XLEN-1:0]           wdata,
  output logic [XLEN-1:0]           ld_data
);
  localparam int SW = XLEN / 8;
  int o, nb, avail;
  logic sgn;
  logic [XLEN-1:0] sh, st;
  // bytes past the end of the word are simply not accessed: no second beat
  always_comb begin
    o = int'(off);
    nb = 1 << size;
    avail = (o + nb > SW) ? SW - o : nb;
    sh = rdata >> (8 * o);
    st = sh >> (8 * avail - 1);
    sgn = st[0] & !(is_unsigned && size != SZ_D);
  end
  assign wdata = store_data << (8 * o);
  for (genvar b = 0; b < SW; b++) begin : g_lane
    assign wstrb[b] = b >= o && b < o + nb;
    assign ld_data[8*b+:8] = b < avail ? sh[8*b+:8] : {8{sgn}};
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: sized load/store memory stage with cache handshake; MEM_MISALIGN_TRAP_EN adds misalign trap
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = 64,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              is_flush,
  output logic              stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic [PC_W-1:0]   wb_pc,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              wb_exc,
  output logic [XLEN-1:0]   wb_exc_addr,
`endif
  output logic              cache_req,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [XLEN-1:0]   cache_wdata,
  output logic [XLEN/8-1:0] cache_wstrb,
  input  logic [XLEN-1:0]   cache_rdata,
  input  logic              cache_done
);
  localparam int SW = XLEN / 8;
  localparam int OW = $clog2(SW);
  lsu_state_e state, state_n;
  logic [XLEN-1:0] addr_q, sdata_q, rdata_q, wdata, ld_data;
  logic [SW-1:0] wstrb;
  mem_size_e size_q;
  logic uns_q, ld_q, flushed_q, mem_op, mis, accept_mem, in_req;
  logic [RD_W-1:0] rd_q;
  logic [PC_W-1:0] pc_q;
  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off(addr_q[OW-1:0]), .size(size_q), .is_unsigned(uns_q), .store_data(sdata_q),
    .rdata(rdata_q), .wstrb(wstrb), .wdata(wdata), .ld_data(ld_data)
  );
  always_comb begin
    mem_op = in_is_load | in_is_store;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = misaligned(in_alu_result[OFF_W-1:0], mem_size_e'(in_size));
`else
    mis = 1'b0;
`endif
    accept_mem = state == IDLE && in_valid && mem_op && !is_flush && !mis;
    in_req = state == REQ;
    state_n = state == IDLE ? (accept_mem ? REQ : IDLE) : in_req ? (cache_done ? RESP : REQ) : IDLE;
    stall = !rst && (accept_mem || in_req);
    cache_req = in_req;
    cache_we = in_req && !ld_q;
    cache_addr = in_req ? ADDR_W'({addr_q[XLEN-1:OW], {OW{1'b0}}}) : '0;
    cache_wdata = cache_we ? wdata : '0;
    cache_wstrb = cache_we ? wstrb : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flushed_q <= 1'b0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_pc <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_exc <= 1'b0;
      wb_exc_addr <= '0;
`endif
    end else begin
      state <= state_n;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_pc <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_exc <= 1'b0;
      wb_exc_addr <= '0;
`endif
      // ALU ops and trapped accesses retire one cycle after acceptance
      if (state == IDLE && in_valid && (!mem_op || (mis && !is_flush))) begin
        wb_valid <= 1'b1;
        wb_data <= in_alu_result;
        wb_rd <= (mem_op || is_flush) ? '0 : in_rd;
        wb_pc <= in_pc;
`ifdef MEM_MISALIGN_TRAP_EN
        wb_exc <= mis;
        wb_exc_addr <= mis ? in_alu_result : '0;
`endif
      end
      if (accept_mem) begin
        addr_q <= in_alu_result;
        sdata_q <= in_store_data;
        size_q <= mem_size_e'(in_size);
        uns_q <= in_unsigned;
        ld_q <= in_is_load;
        rd_q <= in_rd;
        pc_q <= in_pc;
        flushed_q <= 1'b0;
      end
      if (in_req && is_flush) flushed_q <= 1'b1;
      if (in_req && cache_done) rdata_q <= cache_rdata;
      if (state == RESP) begin
        wb_valid <= 1'b1;
        wb_data <= ld_q ? ld_data : addr_q;
        wb_rd <= (ld_q && !flushed_q) ? rd_q : '0;
        wb_pc <= pc_q;
      end
    end
  end
endmodule
